pattern_prog_ctrl: RTL and testbench

PATTERN_PROG_CTRL -- requirements
Module: pattern_prog_ctrl

---
 rtl/pattern_prog_ctrl_if.sv | 25 ++
 rtl/pattern_prog_ctrl.sv | 157 +++++++++++++++
 tb/tb_pattern_prog_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_prog_ctrl_if.sv
// Single-bit detector configuration bus: controller drives address/data/strobes,
// detector answers with pready.
interface pattern_prog_ctrl_if;
  logic paddr;
  logic pwdata;
  logic pwrite;
  logic penable;
  logic pready;

  modport master (
    output paddr,
    output pwdata,
    output pwrite,
    output penable,
    input  pready
  );

  modport slave (
    input  paddr,
    input  pwdata,
    input  pwrite,
    input  penable,
    output pready
  );
endinterface

// File: rtl/pattern_prog_ctrl.sv
// Reprograms a serial pattern detector over a two-phase write bus: disarm,
// shift in the pattern MSB first, re-arm. Also counts detector matches while armed.
module pattern_prog_ctrl #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned TMO   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [PAT_W-1:0]     cfg_pattern,
  input  logic [3:0]           cfg_len,
  pattern_prog_ctrl_if.master  bus,
  input  logic                 pattern_det,
  output logic                 armed,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 cnt_clr,
  output logic [15:0]          det_count
);

  localparam int unsigned TmoW = $clog2(TMO + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StFinish} state_e;

  state_e            state_q, state_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [3:0]        len_q, len_d;
  logic [4:0]        idx_q, idx_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              armed_q, armed_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;

  logic len_ok;
  logic last_wr;
  logic wr_addr;
  logic wr_data;
  logic clr_cnt;

  assign len_ok  = (cfg_len != 4'd0) && (32'(cfg_len) <= PAT_W);
  // Write index: 0 = disarm, 1..len = pattern bits, len+1 = arm.
  assign last_wr = (idx_q == (5'(len_q) + 5'd1));
  assign wr_addr = (idx_q == 5'd0) || last_wr;
  // Pattern is held MSB-aligned so the next bit to send is always the top bit.
  assign wr_data = last_wr ? 1'b1 : ((idx_q == 5'd0) ? 1'b0 : pat_q[PAT_W-1]);

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    armed_d     = armed_q;
    err_d       = 1'b0;
    clr_cnt     = 1'b0;
    bus.paddr   = 1'b0;
    bus.pwdata  = 1'b0;
    bus.pwrite  = 1'b0;
    bus.penable = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          if (len_ok) begin
            pat_d   = cfg_pattern << (PAT_W - 32'(cfg_len));
            len_d   = cfg_len;
            idx_d   = 5'd0;
            armed_d = 1'b0;
            clr_cnt = 1'b1;
            state_d = StSetup;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSetup: begin
        bus.paddr  = wr_addr;
        bus.pwdata = wr_data;
        bus.pwrite = 1'b1;
        tmo_d      = '0;
        state_d    = StAccess;
      end
      StAccess: begin
        bus.paddr   = wr_addr;
        bus.pwdata  = wr_data;
        bus.pwrite  = 1'b1;
        bus.penable = 1'b1;
        if (bus.pready) begin
          if (last_wr) begin
            armed_d = 1'b1;
            state_d = StFinish;
          end else begin
            if (idx_q != 5'd0) begin
              pat_d = pat_q << 1;
            end
            idx_d   = idx_q + 5'd1;
            state_d = StSetup;
          end
        end else if (tmo_q == TmoW'(TMO - 1)) begin
          armed_d = 1'b0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Clearing (host or new program) wins over a same-cycle match.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr || clr_cnt) begin
      cnt_d = 16'd0;
    end else if (armed_q && pattern_det && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pat_q   <= '0;
      len_q   <= 4'd0;
      idx_q   <= 5'd0;
      tmo_q   <= '0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      armed_q <= armed_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cfg_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFinish);
  assign err       = err_q;
  assign armed     = armed_q;
  assign det_count = cnt_q;

endmodule

// File: tb/tb_pattern_prog_ctrl.sv
// Directed/randomized bench for pattern_prog_ctrl with a spec-level model of the
// write sequence and the match counter.
module tb_pattern_prog_ctrl;
  localparam int PAT_W = 8;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        pattern_det;
  logic        armed;
  logic        busy;
  logic        done;
  logic        err;
  logic        cnt_clr;
  logic [15:0] det_count;

  pattern_prog_ctrl_if bus ();

  pattern_prog_ctrl #(
    .PAT_W(PAT_W),
    .TMO  (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .bus        (bus),
    .pattern_det(pattern_det),
    .armed      (armed),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cnt_clr    (cnt_clr),
    .det_count  (det_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int model_cnt = 0;
  bit model_armed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; the counter model sees the inputs that the DUT samples at this edge.
  task automatic tick();
    if (cnt_clr) model_cnt = 0;
    else if (model_armed && pattern_det && model_cnt < 65535) model_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus_idle(input string tag);
    chk({tag, "_paddr"}, bus.paddr, 0);
    chk({tag, "_pwdata"}, bus.pwdata, 0);
    chk({tag, "_pwrite"}, bus.pwrite, 0);
    chk({tag, "_penable"}, bus.penable, 0);
  endtask

  task automatic prog(input logic [7:0] pat, input int len, input int wait_fix,
                      input bit hold_valid, output int lat);
    logic [1:0] exp_w[$];
    int cyc;
    int w;
    exp_w.delete();
    exp_w.push_back(2'b10);
    for (int i = len - 1; i >= 0; i--) exp_w.push_back({1'b0, pat[i]});
    exp_w.push_back(2'b11);

    chk("pre_cfg_ready", cfg_ready, 1);
    cfg_valid   = 1'b1;
    cfg_pattern = pat;
    cfg_len     = 4'(len);
    tick();
    model_armed = 1'b0;
    model_cnt   = 0;
    if (hold_valid) begin
      cfg_len     = 4'd0;
      cfg_pattern = 8'hA5;
    end else begin
      cfg_valid = 1'b0;
    end
    cyc = 1;
    foreach (exp_w[k]) begin
      chk("setup_pwrite", bus.pwrite, 1);
      chk("setup_penable", bus.penable, 0);
      chk("setup_paddr", bus.paddr, exp_w[k][1]);
      chk("setup_pwdata", bus.pwdata, exp_w[k][0]);
      chk("setup_cfg_ready", cfg_ready, 0);
      bus.pready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
      w = (wait_fix >= 0) ? wait_fix : int'($urandom_range(0, 3));
      for (int i = 0; i <= w; i++) begin
        chk("access_penable", bus.penable, 1);
        chk("access_pwrite", bus.pwrite, 1);
        chk("access_paddr", bus.paddr, exp_w[k][1]);
        chk("access_pwdata", bus.pwdata, exp_w[k][0]);
        chk("access_err", err, 0);
        bus.pready = (i == w);
        tick();
        cyc++;
      end
      bus.pready = 1'b0;
    end
    model_armed = 1'b1;
    lat = cyc;
    cfg_valid = 1'b0;
    chk("finish_done", done, 1);
    chk("finish_armed", armed, 1);
    chk("finish_busy", busy, 1);
    chk_bus_idle("finish");
    tick();
    chk("idle_done", done, 0);
    chk("idle_cfg_ready", cfg_ready, 1);
    chk("idle_err", err, 0);
    chk("idle_armed", armed, 1);
  endtask

  task automatic bad_len(input int len);
    chk("rej_cfg_ready", cfg_ready, 1);
    cfg_valid   = 1'b1;
    cfg_pattern = 8'($urandom);
    cfg_len     = 4'(len);
    tick();
    cfg_valid = 1'b0;
    chk("rej_err", err, 1);
    chk("rej_busy", busy, 0);
    chk("rej_armed", armed, model_armed);
    chk("rej_count", det_count, model_cnt);
    chk_bus_idle("rej");
    tick();
    chk("rej_err_end", err, 0);
    chk_bus_idle("rej_after");
  endtask

  initial begin
    int lat;
    logic [7:0] rp;
    int rl;
    rst = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0;
    pattern_det = 1'b0; cnt_clr = 1'b0; bus.pready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_armed", armed, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_count", det_count, 0);
    chk_bus_idle("rst");

    // Reference program, zero-wait and three-wait detector
    prog(8'b1011_0000, 4, 0, 1'b0, lat);
    chk("lat_zero_wait", lat, 2 * (4 + 2) + 1);
    prog(8'b1011_0000, 4, 3, 1'b0, lat);
    chk("lat_wait3", lat, 31);

    // Random configs and waits; cfg_valid kept high while busy must be ignored
    for (int n = 0; n < 6; n++) begin
      rp = 8'($urandom);
      rl = int'($urandom_range(1, PAT_W));
      prog(rp, rl, -1, 1'b1, lat);
    end

    // Random match stream while armed
    for (int n = 0; n < 40; n++) begin
      pattern_det = 1'($urandom_range(0, 1));
      cnt_clr     = ($urandom_range(0, 7) == 0);
      tick();
      chk("cnt_random", det_count, model_cnt);
    end
    pattern_det = 1'b0;
    cnt_clr     = 1'b0;
    tick();

    // Rejected lengths leave armed/count alone
    bad_len(0);
    bad_len(9);
    bad_len(15);

    // Five matches with a clear on the third
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_cleared", det_count, 0);
    for (int n = 0; n < 5; n++) begin
      pattern_det = 1'b1;
      cnt_clr     = (n == 2);
      tick();
    end
    pattern_det = 1'b0;
    cnt_clr     = 1'b0;
    chk("cnt_five", det_count, 2);
    chk("cnt_five_model", det_count, model_cnt);

    // Saturation
    pattern_det = 1'b1;
    for (int n = 0; n < 65540; n++) tick();
    pattern_det = 1'b0;
    chk("cnt_sat", det_count, 16'hFFFF);
    tick();
    chk("cnt_sat_hold", det_count, 16'hFFFF);

    // Timeout with pready stuck low
    cfg_valid = 1'b1; cfg_pattern = 8'h5A; cfg_len = 4'd6;
    tick();
    cfg_valid = 1'b0;
    model_armed = 1'b0;
    model_cnt   = 0;
    chk("tmo_setup", bus.pwrite & ~bus.penable, 1);
    tick();
    for (int n = 0; n < TMO; n++) begin
      chk("tmo_access_penable", bus.penable, 1);
      chk("tmo_access_err", err, 0);
      tick();
    end
    chk("tmo_err", err, 1);
    chk("tmo_armed", armed, 0);
    chk("tmo_cfg_ready", cfg_ready, 1);
    chk_bus_idle("tmo");
    tick();
    chk("tmo_err_end", err, 0);

    // Matches while disarmed are not counted
    pattern_det = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("cnt_disarmed", det_count, model_cnt);
    end
    pattern_det = 1'b0;
    chk("cnt_disarmed_zero", det_count, 0);

    // Reset during the third write's access phase
    bus.pready = 1'b1;
    cfg_valid = 1'b1; cfg_pattern = 8'hF0; cfg_len = 4'd4;
    tick();
    cfg_valid = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    chk("rst_mid_in_access", bus.penable, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_armed = 1'b0;
    model_cnt   = 0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", cfg_ready, 1);
    chk("rst_mid_armed", armed, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_err", err, 0);
    chk("rst_mid_count", det_count, 0);
    chk_bus_idle("rst_mid");
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("rst_mid_quiet", {bus.pwrite, bus.penable, done}, 0);
    end
    bus.pready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
